// File: rtl/seqlogic_pkg.sv
// Shared types and helpers for the sequential datapath cells.
package seqlogic_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    HOLD     = 3'd0,
    SHIFT_UP = 3'd1,
    SHIFT_DN = 3'd2,
    ROT_UP   = 3'd3,
    ROT_DN   = 3'd4,
    LOAD     = 3'd5
  } shift_mode_t;

  typedef enum logic [1:0] {
    SEL_SELF = 2'd0,
    SEL_LO   = 2'd1,
    SEL_HI   = 2'd2,
    SEL_PAR  = 2'd3
  } stage_sel_t;

  function automatic int unsigned fill_cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/usr_stage.sv
// One WIDTH-bit stage: async reset, sync clear/preset, 4:1 next-value mux.
module usr_stage
  import seqlogic_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclr,
  input  logic             spst,
  input  stage_sel_t       sel,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] par_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (sclr) begin
      data_d = '0;
    end else if (spst) begin
      data_d = PRESET_VAL;
    end else begin
      unique case (sel)
        SEL_LO:  data_d = lo_in;
        SEL_HI:  data_d = hi_in;
        SEL_PAR: data_d = par_in;
        default: data_d = data_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= RESET_VAL;
    else     data_q <= data_d;
  end

  assign data_out = data_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: DEPTH x WIDTH stages with shift/rotate/load
// modes and a saturating fill level.
module univ_shift_reg
  import seqlogic_pkg::*;
#(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          sclr,
  input  logic                          spst,
  input  logic [MODE_W-1:0]             mode,
  input  logic [WIDTH-1:0]              ser_in_lo,
  input  logic [WIDTH-1:0]              ser_in_hi,
  input  logic [WIDTH*DEPTH-1:0]        par_in,
  output logic [WIDTH*DEPTH-1:0]        par_out,
  output logic [WIDTH-1:0]              ser_out_lo,
  output logic [WIDTH-1:0]              ser_out_hi,
  output logic [fill_cnt_w(DEPTH)-1:0]  fill_cnt,
  output logic                          full
);

  localparam int unsigned        FW      = fill_cnt_w(DEPTH);
  localparam logic [FW-1:0]      DEPTH_C = FW'(DEPTH);

  logic [WIDTH-1:0] stage [DEPTH];
  stage_sel_t       sel;
  logic [FW-1:0]    fill_d, fill_q;

  // One select drives every stage; edge stages differ only in which
  // neighbour value (serial input or wrap-around) feeds the mux.
  always_comb begin
    sel = SEL_SELF;
    if (en) begin
      case (mode)
        SHIFT_UP, ROT_UP: sel = SEL_LO;
        SHIFT_DN, ROT_DN: sel = SEL_HI;
        LOAD:             sel = SEL_PAR;
        default:          sel = SEL_SELF;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] lo_in, hi_in;

    if (i == 0) begin : g_lo_edge
      assign lo_in = (mode == ROT_UP) ? stage[DEPTH-1] : ser_in_lo;
    end else begin : g_lo_mid
      assign lo_in = stage[i-1];
    end

    if (i == DEPTH - 1) begin : g_hi_edge
      assign hi_in = (mode == ROT_DN) ? stage[0] : ser_in_hi;
    end else begin : g_hi_mid
      assign hi_in = stage[i+1];
    end

    usr_stage #(
      .WIDTH      (WIDTH),
      .RESET_VAL  (RESET_VAL),
      .PRESET_VAL (PRESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .sclr     (sclr),
      .spst     (spst),
      .sel      (sel),
      .lo_in    (lo_in),
      .hi_in    (hi_in),
      .par_in   (par_in[i*WIDTH +: WIDTH]),
      .data_out (stage[i])
    );

    assign par_out[i*WIDTH +: WIDTH] = stage[i];
  end

  always_comb begin
    fill_d = fill_q;
    if (sclr) begin
      fill_d = '0;
    end else if (spst) begin
      fill_d = DEPTH_C;
    end else if (en) begin
      case (mode)
        SHIFT_UP, SHIFT_DN: if (fill_q != DEPTH_C) fill_d = fill_q + 1'b1;
        LOAD:               fill_d = DEPTH_C;
        default:            fill_d = fill_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fill_q <= '0;
    else     fill_q <= fill_d;
  end

  assign ser_out_lo = stage[0];
  assign ser_out_hi = stage[DEPTH-1];
  assign fill_cnt   = fill_q;
  assign full       = (fill_q == DEPTH_C);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed, table-driven bench for univ_shift_reg (WIDTH=8, DEPTH=4).
module tb_univ_shift_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        sclr = 1'b0;
  logic        spst = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [7:0]  ser_in_lo = '0;
  logic [7:0]  ser_in_hi = '0;
  logic [31:0] par_in = '0;
  logic [31:0] par_out;
  logic [7:0]  ser_out_lo, ser_out_hi;
  logic [2:0]  fill_cnt;
  logic        full;

  int n_cmp = 0;
  int n_bad = 0;

  univ_shift_reg #(
    .WIDTH      (8),
    .DEPTH      (4),
    .RESET_VAL  (8'h00),
    .PRESET_VAL (8'hFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sclr       (sclr),
    .spst       (spst),
    .mode       (mode),
    .ser_in_lo  (ser_in_lo),
    .ser_in_hi  (ser_in_hi),
    .par_in     (par_in),
    .par_out    (par_out),
    .ser_out_lo (ser_out_lo),
    .ser_out_hi (ser_out_hi),
    .fill_cnt   (fill_cnt),
    .full       (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en, sclr, spst;
    logic [2:0]  mode;
    logic [7:0]  slo, shi;
    logic [31:0] pin;
    logic [31:0] exp_par;
    logic [2:0]  exp_fill;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, logic e, logic c, logic p, logic [2:0] m,
                              logic [7:0] slo, logic [7:0] shi, logic [31:0] pin,
                              logic [31:0] exp_par, logic [2:0] exp_fill);
    vec_t v;
    v.name = name; v.en = e; v.sclr = c; v.spst = p; v.mode = m;
    v.slo = slo; v.shi = shi; v.pin = pin; v.exp_par = exp_par; v.exp_fill = exp_fill;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] exp_par, input logic [2:0] exp_fill);
    logic [7:0] exp_lo, exp_hi;
    exp_lo = exp_par[7:0];
    exp_hi = exp_par[31:24];
    check({name, ".par_out"},    par_out,            exp_par);
    check({name, ".fill_cnt"},   {29'd0, fill_cnt},  {29'd0, exp_fill});
    check({name, ".full"},       {31'd0, full},      {31'd0, (exp_fill == 3'd4)});
    check({name, ".ser_out_lo"}, {24'd0, ser_out_lo}, {24'd0, exp_lo});
    check({name, ".ser_out_hi"}, {24'd0, ser_out_hi}, {24'd0, exp_hi});
  endtask

  task automatic drive(input vec_t v);
    en = v.en; sclr = v.sclr; spst = v.spst; mode = v.mode;
    ser_in_lo = v.slo; ser_in_hi = v.shi; par_in = v.pin;
  endtask

  initial begin
    // name, en, sclr, spst, mode, ser_lo, ser_hi, par_in, exp_par, exp_fill
    vq.push_back(mk("shup1",  1, 0, 0, 3'd1, 8'h11, 8'h00, 32'h0,        32'h00000011, 3'd1));
    vq.push_back(mk("shup2",  1, 0, 0, 3'd1, 8'h22, 8'h00, 32'h0,        32'h00001122, 3'd2));
    vq.push_back(mk("shup3",  1, 0, 0, 3'd1, 8'h33, 8'h00, 32'h0,        32'h00112233, 3'd3));
    vq.push_back(mk("shup4",  1, 0, 0, 3'd1, 8'h44, 8'h00, 32'h0,        32'h11223344, 3'd4));
    vq.push_back(mk("shup5",  1, 0, 0, 3'd1, 8'h55, 8'h00, 32'h0,        32'h22334455, 3'd4));
    vq.push_back(mk("load1",  1, 0, 0, 3'd5, 8'h00, 8'h00, 32'hA1B2C3D4, 32'hA1B2C3D4, 3'd4));
    vq.push_back(mk("rotup",  1, 0, 0, 3'd3, 8'h99, 8'h99, 32'h0,        32'hB2C3D4A1, 3'd4));
    vq.push_back(mk("rotdn1", 1, 0, 0, 3'd4, 8'h99, 8'h99, 32'h0,        32'hA1B2C3D4, 3'd4));
    vq.push_back(mk("rotdn2", 1, 0, 0, 3'd4, 8'h99, 8'h99, 32'h0,        32'hD4A1B2C3, 3'd4));
    vq.push_back(mk("load2",  1, 0, 0, 3'd5, 8'h00, 8'h00, 32'h01020304, 32'h01020304, 3'd4));
    vq.push_back(mk("shdn",   1, 0, 0, 3'd2, 8'h00, 8'hEE, 32'h0,        32'hEE010203, 3'd4));
    vq.push_back(mk("clrpst", 0, 1, 1, 3'd0, 8'h00, 8'h00, 32'h0,        32'h00000000, 3'd0));
    vq.push_back(mk("pst_en0",0, 0, 1, 3'd0, 8'h00, 8'h00, 32'h0,        32'hFFFFFFFF, 3'd4));
    vq.push_back(mk("rsv6",   1, 0, 0, 3'd6, 8'h12, 8'h34, 32'h55667788, 32'hFFFFFFFF, 3'd4));
    vq.push_back(mk("rsv7",   1, 0, 0, 3'd7, 8'h12, 8'h34, 32'h55667788, 32'hFFFFFFFF, 3'd4));
    vq.push_back(mk("en0shup",0, 0, 0, 3'd1, 8'h99, 8'h99, 32'h0,        32'hFFFFFFFF, 3'd4));
    vq.push_back(mk("clr",    1, 1, 0, 3'd5, 8'h00, 8'h00, 32'h12345678, 32'h00000000, 3'd0));
    vq.push_back(mk("shdn_p", 1, 0, 0, 3'd2, 8'h00, 8'h5A, 32'h0,        32'h5A000000, 3'd1));
    vq.push_back(mk("rot_p",  1, 0, 0, 3'd3, 8'h77, 8'h77, 32'h0,        32'h0000005A, 3'd1));
    vq.push_back(mk("en0load",0, 0, 0, 3'd5, 8'h00, 8'h00, 32'hCAFEBABE, 32'h0000005A, 3'd1));
    vq.push_back(mk("hold",   1, 0, 0, 3'd0, 8'h66, 8'h66, 32'hCAFEBABE, 32'h0000005A, 3'd1));
    vq.push_back(mk("pst_ovr",1, 0, 1, 3'd1, 8'h66, 8'h66, 32'h0,        32'hFFFFFFFF, 3'd4));

    // Async reset between edges, with a LOAD request present.
    en = 1'b1; mode = 3'd5; par_in = 32'hDEADBEEF;
    #3 rst = 1'b1;
    #1 check_all("rst_async", 32'h00000000, 3'd0);
    @(posedge clk); #1;
    check_all("rst_held", 32'h00000000, 3'd0);
    rst = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i]);
      @(posedge clk); #1;
      check_all(vq[i].name, vq[i].exp_par, vq[i].exp_fill);
    end

    // Reset in the middle of a shift sequence, then resume.
    en = 1'b1; sclr = 1'b0; spst = 1'b0; mode = 3'd1; ser_in_lo = 8'h77;
    @(posedge clk); #1;
    check_all("pre_rst_shift", 32'hFFFFFF77, 3'd4);
    #2 rst = 1'b1;
    #1 check_all("rst_mid", 32'h00000000, 3'd0);
    @(posedge clk); #1;
    check_all("rst_mid_held", 32'h00000000, 3'd0);
    rst = 1'b0; ser_in_lo = 8'h12;
    @(posedge clk); #1;
    check_all("post_rst_shift", 32'h00000012, 3'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
